// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control-unit FSM for the multi-cycle CPU datapath.
// Sequences each instruction through IF/ID/EXE/MEM/WB-style states and
// drives every datapath enable and mux select.
// Ports:
//   clk, Reset (sync, active-low)
//   opcode (IR[31:26]), zero/sign (ALU flags)
//   state (debug), PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp[2:0],
//   ExtSel, RegWre, RegDst[1:0], WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc[1:0]
module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [1:0] PCSrc
);

  typedef enum logic [2:0] {
    IF  = 3'b000,
    ID  = 3'b001,
    LS  = 3'b010,
    MEM = 3'b011,
    WBL = 3'b100,
    BR  = 3'b101,
    EXE = 3'b110,
    WBA = 3'b111
  } stateT;

  localparam logic [5:0] opAdd  = 6'b000000;
  localparam logic [5:0] opSub  = 6'b000001;
  localparam logic [5:0] opAddi = 6'b000010;
  localparam logic [5:0] opOr   = 6'b010000;
  localparam logic [5:0] opAnd  = 6'b010001;
  localparam logic [5:0] opOri  = 6'b010010;
  localparam logic [5:0] opSll  = 6'b011000;
  localparam logic [5:0] opSlti = 6'b100110;
  localparam logic [5:0] opSw   = 6'b110000;
  localparam logic [5:0] opLw   = 6'b110001;
  localparam logic [5:0] opBeq  = 6'b110100;
  localparam logic [5:0] opBne  = 6'b110101;
  localparam logic [5:0] opBltz = 6'b110110;
  localparam logic [5:0] opJ    = 6'b111000;
  localparam logic [5:0] opJr   = 6'b111001;
  localparam logic [5:0] opJal  = 6'b111010;
  localparam logic [5:0] opHalt = 6'b111111;

  stateT curState, nextState;

  assign state = curState;

  always_ff @(posedge clk) begin
    if (!Reset) curState <= IF;
    else        curState <= nextState;
  end

  // Opcode classification and ALU control decode
  logic       isArith, isRType, isBranch, isMem, isJump, taken;
  logic [2:0] aluOpDec;
  logic       srcADec, srcBDec, extDec;

  always_comb begin
    isArith  = 1'b0;
    isRType  = 1'b0;
    isBranch = 1'b0;
    isMem    = 1'b0;
    isJump   = 1'b0;
    aluOpDec = 3'b000;
    srcADec  = 1'b0;
    srcBDec  = 1'b0;
    extDec   = 1'b1;
    case (opcode)
      opAdd:  begin isArith = 1'b1; isRType = 1'b1; end
      opSub:  begin isArith = 1'b1; isRType = 1'b1; aluOpDec = 3'b001; end
      opAddi: begin isArith = 1'b1; srcBDec = 1'b1; end
      opOr:   begin isArith = 1'b1; isRType = 1'b1; aluOpDec = 3'b011; end
      opAnd:  begin isArith = 1'b1; isRType = 1'b1; aluOpDec = 3'b100; end
      opOri:  begin isArith = 1'b1; srcBDec = 1'b1; aluOpDec = 3'b011; extDec = 1'b0; end
      opSll:  begin isArith = 1'b1; isRType = 1'b1; aluOpDec = 3'b010; srcADec = 1'b1; end
      opSlti: begin isArith = 1'b1; srcBDec = 1'b1; aluOpDec = 3'b110; end
      opSw, opLw:          isMem    = 1'b1;
      opBeq, opBne, opBltz: isBranch = 1'b1;
      opJ, opJr, opJal:    isJump   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      opBeq:   taken = zero;
      opBne:   taken = ~zero;
      opBltz:  taken = sign;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    nextState = IF;
    case (curState)
      IF: nextState = ID;
      ID: begin
        if (isJump)               nextState = IF;
        else if (isBranch)        nextState = BR;
        else if (isMem)           nextState = LS;
        else if (opcode == opHalt) nextState = ID;
        else if (isArith)         nextState = EXE;
        else                      nextState = IF;
      end
      EXE: nextState = WBA;
      WBA: nextState = IF;
      BR:  nextState = IF;
      LS:  nextState = MEM;
      MEM: nextState = (opcode == opLw) ? WBL : IF;
      WBL: nextState = IF;
      default: nextState = IF;
    endcase
  end

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    ExtSel    = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = 2'b00;
    // Holding Reset low forces every control to 0 so an aborted instruction
    // cannot write anything.
    if (Reset) begin
      case (curState)
        IF: begin
          InsMemRW = 1'b1;
          IRWre    = 1'b1;
        end
        ID: begin
          // Jumps and undefined opcodes retire here; halt and the rest idle.
          if (isJump || (!isBranch && !isMem && !isArith && opcode != opHalt)) begin
            PCWre = 1'b1;
            case (opcode)
              opJ, opJal: PCSrc = 2'b11;
              opJr:       PCSrc = 2'b10;
              default:    PCSrc = 2'b00;
            endcase
            if (opcode == opJal) begin
              RegWre    = 1'b1;
              RegDst    = 2'b00;
              WrRegDSrc = 1'b0;
            end
          end
        end
        EXE, WBA: begin
          ALUOp   = aluOpDec;
          ALUSrcA = srcADec;
          ALUSrcB = srcBDec;
          ExtSel  = extDec;
          if (curState == WBA) begin
            RegWre    = 1'b1;
            RegDst    = isRType ? 2'b10 : 2'b01;
            WrRegDSrc = 1'b1;
            PCWre     = 1'b1;
          end
        end
        BR: begin
          ALUOp  = 3'b001;
          ExtSel = 1'b1;
          PCWre  = 1'b1;
          PCSrc  = taken ? 2'b01 : 2'b00;
        end
        LS, MEM: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          if (curState == MEM) begin
            if (opcode == opLw) begin
              mRD = 1'b1;
            end else begin
              mWR   = 1'b1;
              PCWre = 1'b1;
            end
          end
        end
        WBL: begin
          mRD       = 1'b1;
          DBDataSrc = 1'b1;
          WrRegDSrc = 1'b1;
          RegDst    = 2'b01;
          RegWre    = 1'b1;
          PCWre     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegWre;
  logic       WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [2:0] ALUOp;
  logic [1:0] RegDst, PCSrc;

  multi_cycle_ctrl dut (
    .clk(clk), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
  );

  always #5 clk = ~clk;

  // {PCWre,IRWre,InsMemRW,ALUSrcA,ALUSrcB,ALUOp,ExtSel,RegWre,RegDst,
  //  WrRegDSrc,DBDataSrc,mRD,mWR,PCSrc}
  logic [17:0] actOut;
  assign actOut = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
                   RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc};

  localparam logic [5:0] opAdd  = 6'b000000;
  localparam logic [5:0] opSub  = 6'b000001;
  localparam logic [5:0] opAddi = 6'b000010;
  localparam logic [5:0] opOr   = 6'b010000;
  localparam logic [5:0] opAnd  = 6'b010001;
  localparam logic [5:0] opOri  = 6'b010010;
  localparam logic [5:0] opSll  = 6'b011000;
  localparam logic [5:0] opSlti = 6'b100110;
  localparam logic [5:0] opSw   = 6'b110000;
  localparam logic [5:0] opLw   = 6'b110001;
  localparam logic [5:0] opBeq  = 6'b110100;
  localparam logic [5:0] opBne  = 6'b110101;
  localparam logic [5:0] opBltz = 6'b110110;
  localparam logic [5:0] opJ    = 6'b111000;
  localparam logic [5:0] opJr   = 6'b111001;
  localparam logic [5:0] opJal  = 6'b111010;
  localparam logic [5:0] opHalt = 6'b111111;
  localparam logic [5:0] opUndef = 6'b000011;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        s;
    logic [2:0]  st;
    logic [17:0] out;
  } vecT;

  typedef struct {
    logic [2:0]  st;
    logic [17:0] out;
    int          idx;
  } expT;

  vecT vecs[$];
  expT scoreQ[$];
  int  passed = 0;
  int  total  = 0;

  function automatic logic [17:0] ov(
    input logic pcw, input logic irw, input logic ins, input logic sa,
    input logic sbv, input logic [2:0] op, input logic ext, input logic rw,
    input logic [1:0] rd, input logic wr, input logic db, input logic mrd,
    input logic mwr, input logic [1:0] pcs);
    return {pcw, irw, ins, sa, sbv, op, ext, rw, rd, wr, db, mrd, mwr, pcs};
  endfunction

  function automatic vecT mkv(input logic rst, input logic [5:0] op,
                              input logic z, input logic s,
                              input logic [2:0] st, input logic [17:0] out);
    vecT r;
    r.rst = rst; r.op = op; r.z = z; r.s = s; r.st = st; r.out = out;
    return r;
  endfunction

  function automatic logic [17:0] exeO(input logic [2:0] op, input logic sa,
                                       input logic sbv, input logic ext);
    return ov(1'b0, 1'b0, 1'b0, sa, sbv, op, ext, 1'b0, 2'b00, 1'b0, 1'b0,
              1'b0, 1'b0, 2'b00);
  endfunction

  function automatic logic [17:0] wbaO(input logic [2:0] op, input logic sa,
                                       input logic sbv, input logic ext,
                                       input logic [1:0] rd);
    return ov(1'b1, 1'b0, 1'b0, sa, sbv, op, ext, 1'b1, rd, 1'b1, 1'b0,
              1'b0, 1'b0, 2'b00);
  endfunction

  function automatic logic [17:0] brO(input logic [1:0] pcs);
    return ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0,
              1'b0, 1'b0, 1'b0, pcs);
  endfunction

  logic [17:0] oZero, oIF, oLS, oMemLw, oMemSw, oWbl, oJ, oJr, oJal, oUndef;

  task automatic arith(input logic [5:0] op, input logic [17:0] e,
                       input logic [17:0] w);
    vecs.push_back(mkv(1'b1, op, 1'b0, 1'b0, 3'd0, oIF));
    vecs.push_back(mkv(1'b1, op, 1'b0, 1'b0, 3'd1, oZero));
    vecs.push_back(mkv(1'b1, op, 1'b0, 1'b0, 3'd6, e));
    vecs.push_back(mkv(1'b1, op, 1'b0, 1'b0, 3'd7, w));
  endtask

  task automatic branch(input logic [5:0] op, input logic z, input logic s,
                        input logic [1:0] pcs);
    vecs.push_back(mkv(1'b1, op, z, s, 3'd0, oIF));
    vecs.push_back(mkv(1'b1, op, z, s, 3'd1, oZero));
    vecs.push_back(mkv(1'b1, op, z, s, 3'd5, brO(pcs)));
  endtask

  task automatic jump(input logic [5:0] op, input logic [17:0] o);
    vecs.push_back(mkv(1'b1, op, 1'b0, 1'b0, 3'd0, oIF));
    vecs.push_back(mkv(1'b1, op, 1'b0, 1'b0, 3'd1, o));
  endtask

  task automatic step(input vecT r, input int idx);
    expT e;
    @(posedge clk);
    #1;
    Reset  = r.rst;
    opcode = r.op;
    zero   = r.z;
    sign   = r.s;
    e.st = r.st; e.out = r.out; e.idx = idx;
    scoreQ.push_back(e);
    @(negedge clk);
    e = scoreQ.pop_front();
    total++;
    if (state === e.st) passed++;
    else $display("FAIL state[%0d] got %b want %b", e.idx, state, e.st);
    total++;
    if (actOut === e.out) passed++;
    else $display("FAIL outputs[%0d] got %b want %b", e.idx, actOut, e.out);
    total++;
    if (!(RegWre === 1'b1 && mWR === 1'b1)) passed++;
    else $display("FAIL regwre_mwr[%0d] got both 1 want not both", e.idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    oZero  = '0;
    oIF    = ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    oLS    = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    oMemLw = ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    oMemSw = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    oWbl   = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    oJ     = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    oJr    = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    oJal   = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    oUndef = ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset held low two cycles: state IF, all controls 0.
    vecs.push_back(mkv(1'b0, opAdd, 1'b0, 1'b0, 3'd0, oZero));
    vecs.push_back(mkv(1'b0, opAdd, 1'b0, 1'b0, 3'd0, oZero));
    arith(opAdd,  exeO(3'b000, 1'b0, 1'b0, 1'b1), wbaO(3'b000, 1'b0, 1'b0, 1'b1, 2'b10));
    arith(opSub,  exeO(3'b001, 1'b0, 1'b0, 1'b1), wbaO(3'b001, 1'b0, 1'b0, 1'b1, 2'b10));
    arith(opAddi, exeO(3'b000, 1'b0, 1'b1, 1'b1), wbaO(3'b000, 1'b0, 1'b1, 1'b1, 2'b01));
    arith(opOr,   exeO(3'b011, 1'b0, 1'b0, 1'b1), wbaO(3'b011, 1'b0, 1'b0, 1'b1, 2'b10));
    arith(opAnd,  exeO(3'b100, 1'b0, 1'b0, 1'b1), wbaO(3'b100, 1'b0, 1'b0, 1'b1, 2'b10));
    arith(opOri,  exeO(3'b011, 1'b0, 1'b1, 1'b0), wbaO(3'b011, 1'b0, 1'b1, 1'b0, 2'b01));
    arith(opSll,  exeO(3'b010, 1'b1, 1'b0, 1'b1), wbaO(3'b010, 1'b1, 1'b0, 1'b1, 2'b10));
    arith(opSlti, exeO(3'b110, 1'b0, 1'b1, 1'b1), wbaO(3'b110, 1'b0, 1'b1, 1'b1, 2'b01));
    // lw: five cycles
    vecs.push_back(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd0, oIF));
    vecs.push_back(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd1, oZero));
    vecs.push_back(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd2, oLS));
    vecs.push_back(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd3, oMemLw));
    vecs.push_back(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd4, oWbl));
    // sw: four cycles
    vecs.push_back(mkv(1'b1, opSw, 1'b0, 1'b0, 3'd0, oIF));
    vecs.push_back(mkv(1'b1, opSw, 1'b0, 1'b0, 3'd1, oZero));
    vecs.push_back(mkv(1'b1, opSw, 1'b0, 1'b0, 3'd2, oLS));
    vecs.push_back(mkv(1'b1, opSw, 1'b0, 1'b0, 3'd3, oMemSw));
    branch(opBeq,  1'b1, 1'b0, 2'b01);
    branch(opBeq,  1'b0, 1'b0, 2'b00);
    branch(opBne,  1'b1, 1'b0, 2'b00);
    branch(opBne,  1'b0, 1'b1, 2'b01);
    branch(opBltz, 1'b0, 1'b1, 2'b01);
    branch(opBltz, 1'b1, 1'b0, 2'b00);
    jump(opJ, oJ);
    jump(opJr, oJr);
    jump(opJal, oJal);
    jump(opUndef, oUndef);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // halt: parks in ID with no fetch or PC update until reset.
    step(mkv(1'b1, opHalt, 1'b0, 1'b0, 3'd0, oIF), 1000);
    for (int i = 0; i < 10; i++) step(mkv(1'b1, opHalt, 1'b0, 1'b0, 3'd1, oZero), 1001 + i);
    step(mkv(1'b0, opHalt, 1'b0, 1'b0, 3'd1, oZero), 1011);
    step(mkv(1'b1, opAdd, 1'b0, 1'b0, 3'd0, oIF), 1012);

    // Reset asserted while lw sits in MEM: no mRD/mWR/RegWre, back to IF.
    step(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd1, oZero), 2000);
    step(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd2, oLS), 2001);
    step(mkv(1'b0, opLw, 1'b0, 1'b0, 3'd3, oZero), 2002);
    step(mkv(1'b0, opLw, 1'b0, 1'b0, 3'd0, oZero), 2003);
    step(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd0, oIF), 2004);
    step(mkv(1'b1, opLw, 1'b0, 1'b0, 3'd1, oZero), 2005);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
